// File: rtl/lc3b_types.sv
// Shared widths, arbiter state type and index-width helper for the memory arbiter.
package lc3b_types;

  localparam int LC3B_WORD_WIDTH = 16;
  localparam int LC3B_LINE_WIDTH = 128;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Port-index width; never below one bit so a 2-port arbiter still has an index.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating priority encoder: first pending port at or after start_idx,
// wrapping, optionally skipping excl_idx. Zero latency, no state.
module rr_priority_picker
  import lc3b_types::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IW = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IW-1:0]        start_idx,
  input  logic                 excl_en,
  input  logic [IW-1:0]        excl_idx,
  output logic                 win_vld,
  output logic [IW-1:0]        win_idx
);

  logic [IW:0] cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, start_idx} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_PORTS)) cand = cand - (IW+1)'(NUM_PORTS);
      if (!win_vld && pending[cand[IW-1:0]] &&
          !(excl_en && (cand[IW-1:0] == excl_idx))) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: one grant held until mem_resp, 1-cycle grant latency from IDLE,
// back-to-back handoff on resp. Round-robin; ARB_FIXED_PRIORITY_EN selects lowest-index-first.
module mem_arbiter_rr
  import lc3b_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = LC3B_WORD_WIDTH,
  parameter int DATA_WIDTH = LC3B_LINE_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IW = idx_width(NUM_PORTS);
  localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic [NUM_PORTS-1:0]  pending;
  logic [IW-1:0]         search_base, start_idx, win_idx;
  logic                  busy, win_vld;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign pending = req_read | req_write;
  assign busy    = (state_q == BUSY);

  // On a resp cycle the port being served becomes last, so search starts just past it.
  assign search_base = busy ? grant_q : last_q;
`ifdef ARB_FIXED_PRIORITY_EN
  assign start_idx = '0;
`else
  assign start_idx = (search_base == LAST_PORT) ? '0 : search_base + IW'(1);
`endif

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .pending   (pending),
    .start_idx (start_idx),
    .excl_en   (busy),
    .excl_idx  (grant_q),
    .win_vld   (win_vld),
    .win_idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          last_d = grant_q;
          if (win_vld) grant_d = win_idx;
          else         state_d = IDLE;
        end else if (!pending[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_PORT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Control outputs are gated by rst so a reset cycle never issues a request or resp.
  always_comb begin
    req_resp = '0;
    if (busy && mem_resp && !rst) req_resp[grant_q] = 1'b1;
  end

  assign mem_read    = busy && !rst && !mem_resp && req_read[grant_q];
  assign mem_write   = busy && !rst && !mem_resp && req_write[grant_q];
  assign mem_address = addr_arr[grant_q];
  assign mem_wdata   = wdata_arr[grant_q];
  assign req_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_read, req_write, req_resp;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata, mem_wdata, mem_rdata;
  logic            mem_read, mem_write, mem_resp;
  logic [AW-1:0]   mem_address;
  logic [AW-1:0]   a_arr [N];
  logic [DW-1:0]   d_arr [N];

  always #5 clk = ~clk;

  always_comb begin
    req_address = '0;
    req_wdata   = '0;
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW] = a_arr[i];
      req_wdata[i*DW +: DW]   = d_arr[i];
    end
  end

  mem_arbiter_rr #(
    .NUM_PORTS  (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_resp    (req_resp),
    .req_rdata   (req_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: owner is the port holding the memory port (-1 when idle).
  int           m_owner = -1;
  int           m_last  = N - 1;
  logic [N-1:0] m_resp_prev = '0;
  int           served[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] pend, input int base, input int excl);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int p = 0; p < N; p++)
      if (pend[p] && p != excl) return p;
`else
    for (int off = 1; off <= N; off++) begin
      int p;
      p = (base + off) % N;
      if (pend[p] && p != excl) return p;
    end
`endif
    return -1;
  endfunction

  task automatic set_req(input int p, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[p]  = rd;
    req_write[p] = wr;
    a_arr[p]     = a;
    d_arr[p]     = d;
  endtask

  task automatic clear_req(input int p);
    req_read[p]  = 1'b0;
    req_write[p] = 1'b0;
  endtask

  // Inputs are set during the low phase; check outputs, advance the model, move to next low phase.
  task automatic run_cycle();
    logic [N-1:0] pend, e_resp;
    logic         e_rd, e_wr;
    int           g;
    #1;
    pend   = req_read | req_write;
    e_resp = '0;
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    g      = m_owner;
    if (!rst && g >= 0) begin
      e_rd = req_read[g] && !mem_resp;
      e_wr = req_write[g] && !mem_resp;
      if (mem_resp) e_resp[g] = 1'b1;
      check_eq("mem_address", DW'(mem_address), DW'(a_arr[g]));
      check_eq("mem_wdata", mem_wdata, d_arr[g]);
    end
    check_eq("req_resp", DW'(req_resp), DW'(e_resp));
    check_eq("mem_read", DW'(mem_read), DW'(e_rd));
    check_eq("mem_write", DW'(mem_write), DW'(e_wr));
    check_eq("req_rdata", req_rdata, mem_rdata);
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
    end else if (g < 0) begin
      m_owner = pick(pend, m_last, -1);
    end else if (mem_resp) begin
      m_last  = g;
      m_owner = pick(pend, g, g);
    end else if (!pend[g]) begin
      m_owner = -1;
    end
    m_resp_prev = e_resp;
    for (int i = 0; i < N; i++)
      if (req_resp[i]) served.push_back(i);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req(input int p);
    logic rd;
    rd = 1'($urandom_range(0, 1));
    set_req(p, rd, !rd, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    int age, prev_owner, exp_port;
    rst       = 1'b1;
    req_read  = '0;
    req_write = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    @(negedge clk);
    run_cycle();
    set_req(2, 1'b1, 1'b0, 16'h0055, '0);
    #1;
    check_eq("rst_hold_rd", DW'(mem_read), DW'(0));
    run_cycle();
    clear_req(2);
    rst = 1'b0;
    run_cycle();

    // Single request on port 1
    set_req(1, 1'b1, 1'b0, 16'h1230, '0);
    #1;
    check_eq("single_idle_rd", DW'(mem_read), DW'(0));
    run_cycle();
    #1;
    check_eq("single_addr", DW'(mem_address), DW'(16'h1230));
    check_eq("single_rd_rise", DW'(mem_read), DW'(1));
    run_cycle();
    run_cycle();
    run_cycle();
    mem_resp  = 1'b1;
    mem_rdata = {16{8'hAB}};
    #1;
    check_eq("single_resp", DW'(req_resp), DW'(4'b0010));
    check_eq("single_rdata", req_rdata, {16{8'hAB}});
    run_cycle();
    mem_resp = 1'b0;
    clear_req(1);
    run_cycle();

    // Simultaneous requests after reset
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h1000, '0);
    set_req(1, 1'b1, 1'b0, 16'h2000, '0);
    run_cycle();
    run_cycle();
    mem_resp = 1'b1;
    #1;
    check_eq("simul_first_resp", DW'(req_resp), DW'(4'b0001));
    run_cycle();
    mem_resp = 1'b0;
    clear_req(0);
    #1;
    check_eq("simul_handoff_rd", DW'(mem_read), DW'(1));
    check_eq("simul_handoff_addr", DW'(mem_address), DW'(16'h2000));
    run_cycle();
    mem_resp = 1'b1;
    #1;
    check_eq("simul_second_resp", DW'(req_resp), DW'(4'b0010));
    run_cycle();
    mem_resp = 1'b0;
    clear_req(1);
    run_cycle();

    // Abort, then a stray response while idle
    set_req(2, 1'b0, 1'b1, 16'h3000, {4{32'hC0DE_0002}});
    run_cycle();
    #1;
    check_eq("abort_wr_on", DW'(mem_write), DW'(1));
    run_cycle();
    clear_req(2);
    #1;
    check_eq("abort_wr_drop", DW'(mem_write), DW'(0));
    run_cycle();
    mem_resp = 1'b1;
    #1;
    check_eq("stray_resp", DW'(req_resp), DW'(0));
    run_cycle();
    mem_resp = 1'b0;
    run_cycle();

    // Reset mid-transfer; port 0 must win first afterwards
    set_req(3, 1'b1, 1'b0, 16'h4000, '0);
    run_cycle();
    #1;
    check_eq("rst_pre_rd", DW'(mem_read), DW'(1));
    run_cycle();
    rst      = 1'b1;
    mem_resp = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h5000, '0);
    set_req(2, 1'b1, 1'b0, 16'h6000, '0);
    #1;
    check_eq("rst_mid_rd", DW'(mem_read), DW'(0));
    check_eq("rst_mid_resp", DW'(req_resp), DW'(0));
    run_cycle();
    rst      = 1'b0;
    mem_resp = 1'b0;
    run_cycle();
    #1;
    check_eq("rst_first_grant", DW'(mem_address), DW'(16'h5000));
    check_eq("rst_first_rd", DW'(mem_read), DW'(1));
    run_cycle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) clear_req(i);
    run_cycle();
    rst = 1'b0;
    run_cycle();

    // Continuous requests from every port: service order
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(16'h7000 + i), '0);
    served.delete();
    age = 0;
    for (int c = 0; c < 40; c++) begin
      mem_resp   = (m_owner >= 0) && (age >= 1);
      prev_owner = m_owner;
      run_cycle();
      age = (mem_resp || prev_owner < 0) ? 0 : age + 1;
    end
    mem_resp = 1'b0;
    check_eq("rr_count", DW'(served.size() >= 8), DW'(1));
    for (int k = 0; k < 8 && k < served.size(); k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_port = k % 2;
`else
      exp_port = k % N;
`endif
      check_eq($sformatf("rr_order%0d", k), DW'(served[k]), DW'(exp_port));
    end
    rst = 1'b1;
    for (int i = 0; i < N; i++) clear_req(i);
    run_cycle();
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_resp_prev[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else clear_req(i);
        end else if (!(req_read[i] || req_write[i])) begin
          if ($urandom_range(0, 2) == 0) new_req(i);
        end else if (i == m_owner && $urandom_range(0, 24) == 0) begin
          clear_req(i);
        end
      end
      rst       = ($urandom_range(0, 79) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (m_owner >= 0 && (req_read[m_owner] || req_write[m_owner]))
        mem_resp = ($urandom_range(0, 2) == 0);
      else if (m_owner < 0)
        mem_resp = ($urandom_range(0, 7) == 0);
      else
        mem_resp = 1'b0;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-port memory arbiter sitting between the cache-side requesters (I-cache, D-cache, L2 or victim buffer) and one shared memory port. It grants one requester at a time, holds the grant until the memory port returns resp, and muxes address and write data toward memory. It routes resp and read data back to the winner. Arbitration is round-robin by default, so starvation-free for any port count.

## Interface
- NUM_PORTS, 2: number of requesters; legal range 2..8.
- ADDR_WIDTH, 16: address width in bits.
- DATA_WIDTH, 128: line width in bits.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port read request, held until that port's resp.
- req_write  in  NUM_PORTS  per-port write request, held until that port's resp.
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data; packed the same way as req_address.
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port.
- req_rdata  out  DATA_WIDTH  mem_rdata broadcast; valid only for the port whose req_resp is high.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_WIDTH  downstream read data.

## Operation
- Registers:
  - state: IDLE or BUSY.
  - grant_idx: $clog2(NUM_PORTS) bits.
  - last_idx: last served port, for round-robin.
- Port i is pending when req_read[i] | req_write[i].
- IDLE:
  - All mem_* control outputs and req_resp are 0. Address and data muxes select grant_idx.
  - If any port is pending, pick a winner, load grant_idx, and go to BUSY.
- BUSY:
  - mem_read = req_read[grant_idx], mem_write = req_write[grant_idx].
  - mem_address and mem_wdata come from the granted slice.
  - req_resp[grant_idx] = mem_resp; all other bits are 0.
- BUSY, mem_resp=1:
  - Force mem_read and mem_write to 0 in that cycle.
  - Set last_idx = grant_idx.
  - Pick a winner among pending ports excluding grant_idx. If one exists, load grant_idx and stay BUSY; otherwise go to IDLE.
- BUSY, mem_resp=0 with the granted port no longer pending (abort): go to IDLE with last_idx unchanged.
- Winner selection: search pending ports from last_idx+1 upward, wrapping modulo NUM_PORTS. The first pending port wins.
- A requester asserting read and write together is illegal. The arbiter forwards both unchanged; the bench flags it.

## Timing
- Reset: state=IDLE, grant_idx=0, last_idx=NUM_PORTS-1, so port 0 wins first.
- While rst=1, req_resp, mem_read and mem_write are forced to 0 combinationally.
- Reset mid-transaction abandons the transfer; no req_resp is issued.
- Grant latency:
  - Request sampled at edge k in IDLE gives mem_read/mem_write high from cycle k+1.
  - There is no combinational pass-through from req_* to mem_read/mem_write in IDLE.
- Response is combinational: req_resp[g] is high in the same cycle as mem_resp.
- Back-to-back handoff:
  - The next winner's mem_read/mem_write is asserted in the cycle immediately after mem_resp.
  - The just-served port is never re-granted directly from a resp cycle; it must pass through IDLE or another grant.
- mem_resp while IDLE is ignored; no req_resp is issued.

## Configuration
- ARB_FIXED_PRIORITY_EN:
  - Defined: winner is always the lowest-index pending port, excluding grant_idx on handoff. last_idx is unused. Ports above 0 can starve.
  - Undefined (default): round-robin as described above.

## Structure
- lc3b_types holds arb_state_t (IDLE, BUSY). Address and line widths default from the existing lc3b word and line widths.
- Sub-module rr_priority_picker: purely combinational rotating priority encoder.
  - Inputs: pending mask, start index, exclude enable/index.
  - Outputs: valid, winner index.
  - Under ARB_FIXED_PRIORITY_EN, start is tied to 0.
- Top level holds the FSM, registers and muxes.

## Test plan
- Single request:
  - Stimulus: port 1 req_read, address 0x1230; mem_resp 3 cycles after mem_read rises, mem_rdata=0xAB…
  - Required: mem_address=0x1230 one cycle after the request, req_resp=2'b10, req_rdata=0xAB…
- Simultaneous:
  - Stimulus: ports 0 and 1 request at the same edge after reset.
  - Required: port 0 served first; port 1's mem_read is asserted the cycle after port 0's resp, with no IDLE gap.
- Round-robin, NUM_PORTS=4:
  - Stimulus: all ports request continuously, each re-requesting after its resp.
  - Required: service order 0,1,2,3,0,…
  - With ARB_FIXED_PRIORITY_EN: ports 0 and 1 alternate; 2 and 3 are never served.
- Abort:
  - Stimulus: granted port drops its request before mem_resp.
  - Required: mem_read falls in the next cycle, FSM goes to IDLE, no req_resp.
- Reset mid-transfer:
  - Stimulus: rst asserted in BUSY.
  - Required: mem_read=0 and req_resp=0 in the same cycle; port 0 wins the first grant after reset.
- Stray response:
  - Stimulus: mem_resp pulse while IDLE.
  - Required: all req_resp remain 0.
